lcd_frame_reader: RTL and testbench
===================================

// Module: lcd_frame_reader
// PURPOSE
//  Read-side counterpart of the camera write path. Generates 800x480 LCD raster timing,
//  pops one pixel per active clock from the SDRAM read FIFO pair, and unpacks the
//  two 16-bit words back into 8-bit R/G/B. Also pulses a read-address reload to the
//  SDRAM controller during vertical blanking. Sits between the SDRAM read FIFOs and the LTM pins.
// PARAMETERS
//  H_ACTIVE 800  visible pixels/line;  H_FP 210  front porch;  H_SYNC 1  hsync width;  H_BP 45  back porch
//  V_ACTIVE 480  visible lines/frame;  V_FP 22   front porch;  V_SYNC 1  vsync width;  V_BP 22  back porch
//  SYNC_POL 0    sync active level (0 = active-low)
// PORTS
//  iClk         in   1   pixel clock
//  iRst_n       in   1   reset, synchronous, active-low
//  iEnable      in   1   display run request
//  iRd1_data    in   16  FIFO1 word = {0, G[7:3], B[7:0], 2'bxx}
//  iRd2_data    in   16  FIFO2 word = {0, G[2:0], 2'bxx, R[7:0], 2'bxx}
//  iRd_empty    in   1   either read FIFO empty
//  iClr_flags   in   1   clears oUnderflow
//  oRead        out  1   read request to both FIFOs (normal mode: q valid 1 cycle later)
//  oRd_load     out  1   1-cycle pulse: SDRAM controller reloads frame read address
//  oLCD_R/G/B   out  8   pixel data (3 ports)
//  oDE  oHS  oVS out 1   data enable, hsync, vsync
//  oFrame_start out  1   1-cycle pulse with first active pixel of a frame
//  oUnderflow   out  1   sticky: active pixel requested while FIFO empty
// BEHAVIOUR
//  Reset: state IDLE, counters 0, oRead/oRd_load/oDE/oFrame_start/oUnderflow=0,
//   RGB=0, oHS/oVS = inactive (~SYNC_POL).
//  Counters: h 0..H_TOTAL-1 (H_TOTAL=1056), v 0..V_TOTAL-1 (V_TOTAL=525); h wraps -> v++.
//   Region order per axis: active [0,ACTIVE-1], FP, SYNC, BP.
//  FSM: IDLE -> ARM when iEnable. ARM -> RUN when !iRd_empty (counters start at h=v=0).
//   RUN -> IDLE only at h=H_TOTAL-1, v=V_TOTAL-1 with iEnable=0 (frame always completes).
//   iEnable re-asserted before frame end: stays in RUN. In IDLE/ARM counters held at 0.
//  preDE = RUN && h<H_ACTIVE && v<V_ACTIVE (combinational, cycle t).
//  oRead = preDE && !iRd_empty (never pops an empty FIFO).
//  Cycle t+1 (registered, latency 1 from oRead): oDE=preDE(t); oHS/oVS from h/v(t) in SYNC range;
//   if oDE and read done: R=iRd2_data[9:2], G={iRd1_data[14:10], iRd2_data[14:12]}, B=iRd1_data[9:2];
//   else RGB=0 (blanking and underflow pixels are black).
//  Underflow: preDE && iRd_empty -> oUnderflow<=1 at t+1; raster not stalled. iClr_flags wins
//   over set only when no new underflow in same cycle (set has priority).
//  oRd_load: pulse at h=0, v=V_ACTIVE in RUN (start of vertical blanking), plus once on ARM->RUN.
//  oFrame_start: registered, high with oDE of pixel (0,0).
//  Reset mid-frame: immediate return to reset values; no partial line completed.
// STRUCTURE
//  Package lcd_timing_pkg: H_/V_ defaults, H_TOTAL/V_TOTAL, FSM state encoding
//   (IDLE/ARM/RUN), unpack_rgb function (two words -> 24-bit RGB).
//  Sub-module lcd_timing_gen: h/v counters, region decode, preDE/sync/pulse generation.
//  Top: FSM, FIFO handshake, unpack + output registers, underflow flag.
// TESTING
//  1 Reset: hold iRst_n=0 10 clks -> all outputs reset values, oHS=oVS=1, oRead=0.
//  2 Unpack: iRd1=16'h4A8C, iRd2=16'h3C40 at first active pixel -> R=8'h10, G=8'h93, B=8'hA3, oDE=1.
//  3 Timing: full frame, FIFO never empty -> 800 oRead/line, oHS low 1 clk at h=1010,
//    line period 1056, oVS low 1 line at v=502, 384000 oDE cycles/frame, 1 oRd_load at v=480.
//  4 Underflow: force iRd_empty=1 for pixel (10,5) -> oRead=0 that cycle, RGB=0 next cycle,
//    oUnderflow=1 and sticky; iClr_flags pulse later -> 0.
//  5 Enable drop: deassert iEnable at v=100 -> frame completes to v=524, then IDLE, oDE stays 0.
//  6 Mid-frame reset at v=200,h=400 -> next cycle reset values; re-enable -> ARM, new frame at (0,0)
//    with oFrame_start and oRd_load pulses.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, FSM encoding and pixel unpacking for the LCD read path.
package lcd_timing_pkg;

    // 800x480 panel defaults
    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FP_DEF     = 210;
    localparam int H_SYNC_DEF   = 1;
    localparam int H_BP_DEF     = 45;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 22;
    localparam int V_SYNC_DEF   = 1;
    localparam int V_BP_DEF     = 22;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 1056
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } fsm_state_t;

    // FIFO1 = {0, G[7:3], B[7:0], xx}, FIFO2 = {0, G[2:0], xx, R[7:0], xx}
    // Result is {R, G, B}.
    function automatic logic [23:0] unpack_rgb(input logic [15:0] rd1, input logic [15:0] rd2);
        return {rd2[9:2], rd1[14:10], rd2[14:12], rd1[9:2]};
    endfunction

endpackage

// File: rtl/lcd_timing_gen.sv
// Raster counters and region decode: produces the pre-registered timing strobes
// for one frame of LCD output while the reader is running.
module lcd_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 210,
    parameter int H_SYNC   = 1,
    parameter int H_BP     = 45,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 22,
    parameter int V_SYNC   = 1,
    parameter int V_BP     = 22
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic i_run,
    output logic o_pre_de,
    output logic o_hs_act,
    output logic o_vs_act,
    output logic o_first_pix,
    output logic o_load_pt,
    output logic o_frame_end
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          w_h_last;
    logic          w_v_last;

    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);

    // Raster counters advance only while running; otherwise they park at the origin
    // so the first running cycle is always pixel (0,0).
    always_ff @(posedge iClk) begin
        if (!iRst_n || !i_run) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + VW'(1);
        end else begin
            r_h <= r_h + HW'(1);
        end
    end

    assign o_pre_de    = i_run && (r_h < H_ACT) && (r_v < V_ACT);
    assign o_hs_act    = i_run && (r_h >= H_SYNC_S) && (r_h < H_SYNC_E);
    assign o_vs_act    = i_run && (r_v >= V_SYNC_S) && (r_v < V_SYNC_E);
    assign o_first_pix = i_run && (r_h == '0) && (r_v == '0);
    // Start of vertical blanking: the SDRAM side has the whole blanking time to rewind.
    assign o_load_pt   = i_run && (r_h == '0) && (r_v == V_ACT);
    assign o_frame_end = i_run && w_h_last && w_v_last;

endmodule

// File: rtl/lcd_frame_reader.sv
// LCD read path: run/arm FSM, FIFO pop handshake, RGB unpack and the registered
// timing outputs toward the LTM panel.
module lcd_frame_reader
    import lcd_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iEnable,
    input  logic [15:0] iRd1_data,
    input  logic [15:0] iRd2_data,
    input  logic        iRd_empty,
    input  logic        iClr_flags,
    output logic        oRead,
    output logic        oRd_load,
    output logic [7:0]  oLCD_R,
    output logic [7:0]  oLCD_G,
    output logic [7:0]  oLCD_B,
    output logic        oDE,
    output logic        oHS,
    output logic        oVS,
    output logic        oFrame_start,
    output logic        oUnderflow
);

    fsm_state_t r_state;
    fsm_state_t w_state_next;

    logic w_run;
    logic w_pre_de;
    logic w_hs_act;
    logic w_vs_act;
    logic w_first_pix;
    logic w_load_pt;
    logic w_frame_end;
    logic w_read;
    logic w_load_req;

    logic r_de;
    logic r_hs;
    logic r_vs;
    logic r_rd_done;
    logic r_rd_load;
    logic r_fs;
    logic r_underflow;

    logic [23:0] w_rgb;
    logic [23:0] w_rgb_out;

    assign w_run = (r_state == ST_RUN);

    lcd_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .i_run       (w_run),
        .o_pre_de    (w_pre_de),
        .o_hs_act    (w_hs_act),
        .o_vs_act    (w_vs_act),
        .o_first_pix (w_first_pix),
        .o_load_pt   (w_load_pt),
        .o_frame_end (w_frame_end)
    );

    // FSM state register.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus FIFO pop / reload requests. A running frame is always
    // finished before dropping back to IDLE.
    always_comb begin
        w_state_next = r_state;
        w_read       = 1'b0;
        w_load_req   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iEnable) begin
                    w_state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!iRd_empty) begin
                    w_state_next = ST_RUN;
                    w_load_req   = 1'b1;
                end
            end
            ST_RUN: begin
                w_read     = w_pre_de && !iRd_empty;
                w_load_req = w_load_pt;
                if (w_frame_end && !iEnable) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output timing stage: strobes decoded from the raster in cycle t show up at t+1,
    // the same cycle the FIFO presents the word popped at t.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_de      <= 1'b0;
            r_hs      <= ~SYNC_POL;
            r_vs      <= ~SYNC_POL;
            r_rd_done <= 1'b0;
            r_rd_load <= 1'b0;
            r_fs      <= 1'b0;
        end else begin
            r_de      <= w_pre_de;
            r_hs      <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vs      <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            r_rd_done <= w_read;
            r_rd_load <= w_load_req;
            r_fs      <= w_first_pix;
        end
    end

    // Sticky underflow; a fresh underflow beats a simultaneous clear.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_underflow <= 1'b0;
        end else if (w_pre_de && iRd_empty) begin
            r_underflow <= 1'b1;
        end else if (iClr_flags) begin
            r_underflow <= 1'b0;
        end
    end

    // FIFO q is valid the cycle after the pop, so unpack it directly and black it
    // out whenever no pop happened (blanking or an underflowed pixel).
    assign w_rgb = unpack_rgb(iRd1_data, iRd2_data);

    generate
        for (genvar gi = 0; gi < 24; gi++) begin : g_rgb_gate
            assign w_rgb_out[gi] = w_rgb[gi] & r_rd_done;
        end
    endgenerate

    assign {oLCD_R, oLCD_G, oLCD_B} = w_rgb_out;

    assign oRead        = w_read;
    assign oRd_load     = r_rd_load;
    assign oDE          = r_de;
    assign oHS          = r_hs;
    assign oVS          = r_vs;
    assign oFrame_start = r_fs;
    assign oUnderflow   = r_underflow;

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Directed/randomized bench for lcd_frame_reader using a reduced raster so whole
// frames fit in a short run. Expectations come from a position-based frame model.
module tb_lcd_frame_reader;

    localparam int HA  = 16;
    localparam int HFP = 4;
    localparam int HS  = 2;
    localparam int HBP = 3;
    localparam int VA  = 8;
    localparam int VFP = 2;
    localparam int VS  = 1;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int BOUND = 3000;

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iEnable = 1'b0;
    logic [15:0] iRd1_data = 16'h0;
    logic [15:0] iRd2_data = 16'h0;
    logic        iRd_empty = 1'b1;
    logic        iClr_flags = 1'b0;
    logic        oRead;
    logic        oRd_load;
    logic [7:0]  oLCD_R;
    logic [7:0]  oLCD_G;
    logic [7:0]  oLCD_B;
    logic        oDE;
    logic        oHS;
    logic        oVS;
    logic        oFrame_start;
    logic        oUnderflow;

    always #5 iClk = ~iClk;

    lcd_frame_reader #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_POL (1'b0)
    ) dut (
        .iClk         (iClk),
        .iRst_n       (iRst_n),
        .iEnable      (iEnable),
        .iRd1_data    (iRd1_data),
        .iRd2_data    (iRd2_data),
        .iRd_empty    (iRd_empty),
        .iClr_flags   (iClr_flags),
        .oRead        (oRead),
        .oRd_load     (oRd_load),
        .oLCD_R       (oLCD_R),
        .oLCD_G       (oLCD_G),
        .oLCD_B       (oLCD_B),
        .oDE          (oDE),
        .oHS          (oHS),
        .oVS          (oVS),
        .oFrame_start (oFrame_start),
        .oUnderflow   (oUnderflow)
    );

    // Stimulus controls
    logic g_rst_n = 1'b0;
    logic g_en = 1'b0;
    logic g_empty = 1'b1;
    logic g_clr = 1'b0;
    logic g_fixed = 1'b0;
    logic g_rand_empty = 1'b0;

    // Frame model: running/armed flags and linear position inside the frame
    bit m_run = 1'b0;
    bit m_arm = 1'b0;
    int m_pos = 0;

    // Expected registered outputs for the next sampled cycle
    logic e_de = 1'b0, e_hs = 1'b1, e_vs = 1'b1, e_rd_done = 1'b0;
    logic e_load = 1'b0, e_fs = 1'b0, e_uf = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cnt_de = 0, cnt_rd = 0, cnt_load = 0, cnt_fs = 0, cnt_hs_low = 0, cnt_vs_low = 0;
    int guard;

    function automatic logic [23:0] ref_rgb(input logic [15:0] d1, input logic [15:0] d2);
        logic [7:0] r, g, b;
        r = d2[9:2];
        g = {d1[14:10], d2[14:12]};
        b = d1[9:2];
        return {r, g, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    // One clock: apply inputs after the edge, check at the falling edge, advance model.
    task automatic cycle();
        int  h, v;
        bit  pre;
        logic [23:0] rgb_exp;
        @(posedge iClk);
        #1;
        iRst_n     = g_rst_n;
        iEnable    = g_en;
        iClr_flags = g_clr;
        iRd_empty  = g_rand_empty ? ($urandom_range(0, 7) == 0) : g_empty;
        if (g_fixed && e_fs) begin
            iRd1_data = 16'h4A8C;
            iRd2_data = 16'h3C40;
        end else begin
            iRd1_data = 16'($urandom);
            iRd2_data = 16'($urandom);
        end
        @(negedge iClk);
        chk("oDE", 32'(oDE), 32'(e_de));
        chk("oHS", 32'(oHS), 32'(e_hs));
        chk("oVS", 32'(oVS), 32'(e_vs));
        chk("oRd_load", 32'(oRd_load), 32'(e_load));
        chk("oFrame_start", 32'(oFrame_start), 32'(e_fs));
        chk("oUnderflow", 32'(oUnderflow), 32'(e_uf));
        rgb_exp = e_rd_done ? ref_rgb(iRd1_data, iRd2_data) : 24'h0;
        chk("rgb", 32'({oLCD_R, oLCD_G, oLCD_B}), 32'(rgb_exp));
        cnt_de     += int'(oDE);
        cnt_load   += int'(oRd_load);
        cnt_fs     += int'(oFrame_start);
        cnt_hs_low += int'(!oHS);
        cnt_vs_low += int'(!oVS);

        h   = m_pos % HT;
        v   = m_pos / HT;
        pre = m_run && (h < HA) && (v < VA);
        chk("oRead", 32'(oRead), 32'(pre && !iRd_empty));
        cnt_rd += int'(oRead);

        if (!iRst_n) begin
            m_run = 1'b0; m_arm = 1'b0; m_pos = 0;
            e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rd_done = 1'b0;
            e_load = 1'b0; e_fs = 1'b0; e_uf = 1'b0;
        end else begin
            e_de      = pre;
            e_hs      = !(m_run && h >= HA + HFP && h < HA + HFP + HS);
            e_vs      = !(m_run && v >= VA + VFP && v < VA + VFP + VS);
            e_rd_done = pre && !iRd_empty;
            e_load    = (m_arm && !iRd_empty) || (m_run && m_pos == VA * HT);
            e_fs      = pre && (m_pos == 0);
            if (pre && iRd_empty) e_uf = 1'b1;
            else if (iClr_flags)  e_uf = 1'b0;
            if (m_run) begin
                if (m_pos == FRAME - 1) begin
                    m_pos = 0;
                    if (!iEnable) m_run = 1'b0;
                end else begin
                    m_pos++;
                end
            end else if (m_arm) begin
                if (!iRd_empty) begin
                    m_arm = 1'b0;
                    m_run = 1'b1;
                    m_pos = 0;
                end
            end else if (iEnable) begin
                m_arm = 1'b1;
            end
        end
    endtask

    task automatic clear_counts();
        cnt_de = 0; cnt_rd = 0; cnt_load = 0; cnt_fs = 0; cnt_hs_low = 0; cnt_vs_low = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 10 clocks
        $display("step reset: hold iRst_n low 10 clocks");
        repeat (10) cycle();
        chk("reset_oHS", 32'(oHS), 32'd1);
        chk("reset_oVS", 32'(oVS), 32'd1);
        chk("reset_oRead", 32'(oRead), 32'd0);
        g_rst_n = 1'b1;
        cycle();

        // Arm with FIFOs empty: nothing may be popped
        $display("step arm: enable with empty FIFOs");
        g_en = 1'b1;
        clear_counts();
        repeat (3) cycle();
        chk("arm_no_read", 32'(cnt_rd), 32'd0);

        // First frame, FIFO never empty, known words at the first pixel
        $display("step frame1: start and unpack first pixel");
        g_empty = 1'b0;
        g_fixed = 1'b1;
        for (guard = 0; guard < BOUND && !e_fs; guard++) cycle();
        chk("wait_first_pixel", 32'(guard < BOUND), 32'd1);
        cycle();
        g_fixed = 1'b0;
        chk("unpack_de", 32'(oDE), 32'd1);
        chk("unpack_R", 32'(oLCD_R), 32'h10);
        chk("unpack_G", 32'(oLCD_G), 32'h93);
        chk("unpack_B", 32'(oLCD_B), 32'hA3);

        // Drop enable mid-frame: frame must complete, then idle
        $display("step frame1: drop enable at v=3");
        for (guard = 0; guard < BOUND && !(m_run && m_pos == 3 * HT); guard++) cycle();
        chk("wait_v3", 32'(guard < BOUND), 32'd1);
        g_en = 1'b0;
        for (guard = 0; guard < BOUND && m_run; guard++) cycle();
        chk("wait_frame_end", 32'(guard < BOUND), 32'd1);
        repeat (2 * HT) cycle();
        chk("frame_reads", 32'(cnt_rd), 32'(HA * VA));
        chk("frame_de", 32'(cnt_de), 32'(HA * VA));
        chk("frame_loads", 32'(cnt_load), 32'd2);
        chk("frame_starts", 32'(cnt_fs), 32'd1);
        chk("frame_hs_low", 32'(cnt_hs_low), 32'(HS * VT));
        chk("frame_vs_low", 32'(cnt_vs_low), 32'(VS * HT));
        chk("idle_de", 32'(oDE), 32'd0);

        // Second frame: underflow at pixel (10,5)
        $display("step frame2: underflow at pixel (10,5)");
        g_en = 1'b1;
        for (guard = 0; guard < BOUND && !(m_run && m_pos == 5 * HT + 10); guard++) cycle();
        chk("wait_uf_pixel", 32'(guard < BOUND), 32'd1);
        g_empty = 1'b1;
        cycle();
        chk("uf_no_read", 32'(oRead), 32'd0);
        g_empty = 1'b0;
        cycle();
        chk("uf_rgb_black", 32'({oLCD_R, oLCD_G, oLCD_B}), 32'd0);
        chk("uf_flag", 32'(oUnderflow), 32'd1);
        repeat (5) cycle();
        chk("uf_sticky", 32'(oUnderflow), 32'd1);
        g_clr = 1'b1;
        cycle();
        g_clr = 1'b0;
        cycle();
        chk("uf_cleared", 32'(oUnderflow), 32'd0);

        // Simultaneous underflow and clear: set wins
        $display("step frame2: underflow with concurrent clear at (3,6)");
        for (guard = 0; guard < BOUND && !(m_run && m_pos == 6 * HT + 3); guard++) cycle();
        chk("wait_prio_pixel", 32'(guard < BOUND), 32'd1);
        g_empty = 1'b1;
        g_clr = 1'b1;
        cycle();
        g_empty = 1'b0;
        g_clr = 1'b0;
        cycle();
        chk("uf_set_priority", 32'(oUnderflow), 32'd1);

        // Random FIFO-empty pattern for a line
        $display("step frame2: random empty pattern for one line");
        g_rand_empty = 1'b1;
        repeat (HT) cycle();
        g_rand_empty = 1'b0;

        // Mid-frame reset at (8,4) of the next frame
        $display("step reset mid-frame at (8,4)");
        for (guard = 0; guard < BOUND && !(m_run && m_pos == 4 * HT + 8); guard++) cycle();
        chk("wait_midrst", 32'(guard < BOUND), 32'd1);
        g_rst_n = 1'b0;
        g_en = 1'b0;
        cycle();
        g_rst_n = 1'b1;
        cycle();
        chk("midrst_de", 32'(oDE), 32'd0);
        chk("midrst_hs", 32'(oHS), 32'd1);
        chk("midrst_vs", 32'(oVS), 32'd1);
        chk("midrst_uf", 32'(oUnderflow), 32'd0);
        chk("midrst_rgb", 32'({oLCD_R, oLCD_G, oLCD_B}), 32'd0);

        // Re-enable: new frame from (0,0) with reload and frame-start pulses
        $display("step restart after reset");
        clear_counts();
        g_en = 1'b1;
        for (guard = 0; guard < BOUND && !e_fs; guard++) cycle();
        chk("wait_restart", 32'(guard < BOUND), 32'd1);
        cycle();
        chk("restart_fs", 32'(oFrame_start), 32'd1);
        chk("restart_de", 32'(oDE), 32'd1);
        chk("restart_load", 32'(cnt_load), 32'd1);
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
